regfile_bypass_sb: RTL



---
 rtl/regfile_bypass_sb.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: parametrised architectural register file with
// write-to-read bypass and a per-register busy scoreboard.
// Decode reads operands and allocates destinations.
// Writeback writes results and clears busy bits.
// An asynchronous reset clears all data and busy state.
module regfile_bypass_sb #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [XLEN-1:0]          wd,
  input  logic [NUM_RD*AW-1:0]     ra,
  output logic [NUM_RD*XLEN-1:0]   rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  output logic [CW-1:0]            busy_cnt
);

  logic [XLEN-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [CW-1:0]    busy_cnt_q;
  logic [CW-1:0]    busy_cnt_d;
  logic             do_wr;
  logic             do_alloc;

  // Register 0 is hardwired to zero only when ZERO_REG is set.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Qualified write and allocate. Reset masks both, so the bypass path
  // cannot leak wd onto rd while reset is asserted.
  assign do_wr    = we & ~rst & ~is_zero(wa);
  assign do_alloc = alloc_en & ~rst & ~is_zero(alloc_addr);

  // Next busy vector: writeback clears first, then allocate sets.
  // If both target one register, the new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (do_wr)    busy_d[wa]         = 1'b0;
    if (do_alloc) busy_d[alloc_addr] = 1'b1;
  end

  // busy_cnt is the popcount of the post-edge busy vector.
  // It is recomputed from the vector each cycle rather than incremented.
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
    end
  end

  // Scoreboard state and its count, updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Register storage. An in-flight write is dropped by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr) begin
      mem_q[wa] <= wd;
    end
  end

  // Combinational read ports with same-cycle write bypass and busy lookup.
  // The bypass clears busy unless a same-cycle allocate re-marks the register.
  always_comb begin
    logic [AW-1:0] a;
    a       = '0;
    rd      = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = ra[p*AW +: AW];
      if (is_zero(a)) begin
        rd[p*XLEN +: XLEN] = '0;
        rd_busy[p]         = 1'b0;
      end else if (do_wr && (wa == a)) begin
        rd[p*XLEN +: XLEN] = wd;
        rd_busy[p]         = (do_alloc && (alloc_addr == a)) ? busy_q[a] : 1'b0;
      end else begin
        rd[p*XLEN +: XLEN] = mem_q[a];
        rd_busy[p]         = busy_q[a];
      end
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule
